tm1638_refresh: RTL and testbench

//   Upstream command generator for spi_fifo. Periodically snapshots the display image
//   (8 digit segment bytes, 8 LEDs, brightness/on) and pushes the TM1638 refresh frame

---
 rtl/tm1638_refresh.sv | 124 ++++++++++++
 tb/tb_tm1638_refresh.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tm1638_refresh.sv
// tm1638_refresh: periodic TM1638 refresh-frame generator feeding spi_fifo with 18-bit command words.
module tm1638_refresh #(
  parameter int REFRESH_CYCLES   = 250000,
  parameter bit INCLUDE_KEY_READ = 1'b1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [63:0] i_Segments,
  input  logic [7:0]  i_Leds,
  input  logic [2:0]  i_Brightness,
  input  logic        i_Display_On,
  input  logic        i_FIFO_Full,
  output logic        o_Data_Valid,
  output logic [17:0] o_Data,
  output logic        o_Busy,
  output logic        o_Frame_Done
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  typedef enum logic [2:0] {IDLE, MODE, DATA, CTRL, READ, DONE} state_t;
  state_t      r_State, w_State_Next;
  logic [CW-1:0] r_Count;
  logic        r_Gap, w_Gap_Next, r_Pend, w_Pend_Next;
  logic [3:0]  r_Addr, w_Addr_Next;
  logic        r_Valid, w_Valid_Next, r_Busy, w_Busy_Next, r_Done, w_Done_Next;
  logic [17:0] r_Data, w_Data_Next, w_Word;
  logic [63:0] r_Seg, w_Seg_Next;
  logic [7:0]  r_Led, w_Led_Next, w_Seg_Byte;
  logic [2:0]  r_Bri, w_Bri_Next;
  logic        r_On, w_On_Next;
  logic        w_Tick, w_Start;
  assign w_Tick     = r_Count == '0;
  assign w_Start    = (r_State == IDLE && w_Tick) || (r_State == DONE && (r_Pend || w_Tick));
  assign w_Seg_Byte = r_Seg[{r_Addr[3:1], 3'b000} +: 8];
  assign w_Word = r_State == MODE ? 18'h00044 :
                  r_State == DATA ? {2'b01, 4'hC, r_Addr, r_Addr[0] ? {7'b0, r_Led[r_Addr[3:1]]} : w_Seg_Byte} :
                  r_State == CTRL ? {2'b00, 8'h00, 1'b1, 3'b000, r_On, r_Bri} : 18'h20042;
  always_ff @(posedge i_Clk)
    r_Count <= (i_Rst || r_Count == CW'(REFRESH_CYCLES - 1)) ? '0 : r_Count + CW'(1);
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State <= IDLE;
      r_Gap   <= 1'b0;
      r_Pend  <= 1'b0;
      r_Addr  <= '0;
      r_Valid <= 1'b0;
      r_Data  <= '0;
      r_Busy  <= 1'b0;
      r_Done  <= 1'b0;
      r_Seg   <= '0;
      r_Led   <= '0;
      r_Bri   <= '0;
      r_On    <= 1'b0;
    end else begin
      r_State <= w_State_Next;
      r_Gap   <= w_Gap_Next;
      r_Pend  <= w_Pend_Next;
      r_Addr  <= w_Addr_Next;
      r_Valid <= w_Valid_Next;
      r_Data  <= w_Data_Next;
      r_Busy  <= w_Busy_Next;
      r_Done  <= w_Done_Next;
      r_Seg   <= w_Seg_Next;
      r_Led   <= w_Led_Next;
      r_Bri   <= w_Bri_Next;
      r_On    <= w_On_Next;
    end
  end
  // r_Busy is high exactly in MODE..READ, so it doubles as the "frame in progress" qualifier
  always_comb begin
    w_State_Next = r_State == DONE ? IDLE : r_State;
    w_Gap_Next   = r_Gap;
    w_Pend_Next  = r_Pend | (w_Tick & r_Busy);
    w_Addr_Next  = r_Addr;
    w_Valid_Next = 1'b0;
    w_Data_Next  = r_Data;
    w_Busy_Next  = r_Busy;
    w_Done_Next  = 1'b0;
    w_Seg_Next   = r_Seg;
    w_Led_Next   = r_Led;
    w_Bri_Next   = r_Bri;
    w_On_Next    = r_On;
    if (w_Start) begin
      w_State_Next = MODE;
      w_Busy_Next  = 1'b1;
      w_Pend_Next  = 1'b0;
      w_Gap_Next   = 1'b0;
      w_Seg_Next   = i_Segments;
      w_Led_Next   = i_Leds;
      w_Bri_Next   = i_Brightness;
      w_On_Next    = i_Display_On;
    end else if (r_Busy && r_Gap) begin
      w_Gap_Next = 1'b0;
      unique case (r_State)
        MODE: begin
          w_State_Next = DATA;
          w_Addr_Next  = '0;
        end
        DATA: begin
          w_State_Next = &r_Addr ? CTRL : DATA;
          w_Addr_Next  = r_Addr + 4'd1;
        end
        CTRL: begin
          w_State_Next = INCLUDE_KEY_READ ? READ : DONE;
          w_Done_Next  = !INCLUDE_KEY_READ;
          w_Busy_Next  = INCLUDE_KEY_READ;
        end
        READ: begin
          w_State_Next = DONE;
          w_Done_Next  = 1'b1;
          w_Busy_Next  = 1'b0;
        end
        default: ;
      endcase
    end else if (r_Busy && !i_FIFO_Full) begin
      w_Valid_Next = 1'b1;
      w_Data_Next  = w_Word;
      w_Gap_Next   = 1'b1;
    end
  end
  assign o_Data_Valid = r_Valid;
  assign o_Data       = r_Data;
  assign o_Busy       = r_Busy;
  assign o_Frame_Done = r_Done;
endmodule

// File: tb/tb_tm1638_refresh.sv
// tb_tm1638_refresh: directed scoreboard bench for tm1638_refresh (three parameterisations).
module tb_tm1638_refresh;
  logic        clk = 1'b0, rst = 1'b1;
  logic [63:0] seg;
  logic [7:0]  leds;
  logic [2:0]  bri;
  logic        on;
  logic        full_a = 1'b0, full_b = 1'b0, full_c = 1'b0;
  logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done, c_valid, c_busy, c_done;
  logic [17:0] a_data, b_data, c_data;
  logic [17:0] qa[$], qb[$], qc[$];
  int          checks = 0, errors = 0;
  int          cnt_a = 0, cnt_b = 0, cnt_c = 0, done_a = 0, done_c = 0;
  bit          en_a = 0, en_b = 0, en_c = 0;
  always #5 clk = ~clk;
  tm1638_refresh #(.REFRESH_CYCLES(200), .INCLUDE_KEY_READ(1'b1)) u_a (
    .i_Clk(clk), .i_Rst(rst), .i_Segments(seg), .i_Leds(leds), .i_Brightness(bri),
    .i_Display_On(on), .i_FIFO_Full(full_a), .o_Data_Valid(a_valid), .o_Data(a_data),
    .o_Busy(a_busy), .o_Frame_Done(a_done));
  tm1638_refresh #(.REFRESH_CYCLES(200), .INCLUDE_KEY_READ(1'b0)) u_b (
    .i_Clk(clk), .i_Rst(rst), .i_Segments(seg), .i_Leds(leds), .i_Brightness(bri),
    .i_Display_On(on), .i_FIFO_Full(full_b), .o_Data_Valid(b_valid), .o_Data(b_data),
    .o_Busy(b_busy), .o_Frame_Done(b_done));
  tm1638_refresh #(.REFRESH_CYCLES(64), .INCLUDE_KEY_READ(1'b1)) u_c (
    .i_Clk(clk), .i_Rst(rst), .i_Segments(seg), .i_Leds(leds), .i_Brightness(bri),
    .i_Display_On(on), .i_FIFO_Full(full_c), .o_Data_Valid(c_valid), .o_Data(c_data),
    .o_Busy(c_busy), .o_Frame_Done(c_done));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // 18'h3FFFF can never be emitted, so it marks a push with nothing expected
  always @(negedge clk) begin
    logic [17:0] e;
    if (a_done) done_a++;
    if (c_done) done_c++;
    if (en_a && a_valid) begin
      cnt_a++;
      e = qa.size() ? qa.pop_front() : 18'h3FFFF;
      chk("a_word", 32'(a_data), 32'(e));
    end
    if (en_b && b_valid) begin
      cnt_b++;
      e = qb.size() ? qb.pop_front() : 18'h3FFFF;
      chk("b_word", 32'(b_data), 32'(e));
    end
    if (en_c && c_valid) begin
      cnt_c++;
      e = qc.size() ? qc.pop_front() : 18'h3FFFF;
      chk("c_word", 32'(c_data), 32'(e));
    end
  end
  task automatic push_frame(input int w, input logic [63:0] s, input logic [7:0] l,
                            input logic [2:0] b, input logic o, input bit rd);
    logic [17:0] f[$];
    f.push_back(18'h00044);
    for (int a = 0; a < 16; a++)
      f.push_back({2'b01, 4'hC, 4'(a), (a % 2) ? {7'b0, l[a / 2]} : s[8 * (a / 2) +: 8]});
    f.push_back({10'h000, 1'b1, 3'b000, o, b});
    if (rd) f.push_back(18'h20042);
    foreach (f[i]) begin
      if (w == 0) qa.push_back(f[i]);
      else if (w == 1) qb.push_back(f[i]);
      else qc.push_back(f[i]);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic wait_cnt_a(input int n, input int lim);
    int t = 0;
    while (cnt_a < n && t < lim) begin step(1); t++; end
    chk("wait_push_a", 32'(cnt_a >= n), 32'd1);
  endtask
  task automatic wait_done_a(input int n, input int lim);
    int t = 0;
    while (done_a < n && t < lim) begin step(1); t++; end
    chk("wait_done_a", 32'(done_a >= n), 32'd1);
  endtask
  initial begin
    for (int k = 0; k < 8; k++) seg[8 * k +: 8] = 8'h10 + 8'(k);
    leds = 8'hA5; bri = 3'd5; on = 1'b1;
    step(3);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_data", 32'(a_data), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    en_a = 1;
    push_frame(0, seg, leds, bri, on, 1);
    rst = 1'b0;
    step(1);
    chk("start_busy", 32'(a_busy), 1);
    step(1);
    chk("first_valid", 32'(a_valid), 1);
    wait_done_a(1, 200);
    chk("f1_count", 32'(cnt_a), 19);
    chk("f1_queue", 32'(qa.size()), 0);
    step(1);
    chk("done_pulse", 32'(a_done), 0);
    chk("busy_idle", 32'(a_busy), 0);
    cnt_a = 0;
    push_frame(0, seg, leds, bri, on, 1);
    wait_cnt_a(5, 400);
    full_a = 1'b1;
    seg = {8{8'hFF}};
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("full_novalid", 32'(a_valid), 0);
    end
    full_a = 1'b0;
    wait_done_a(2, 200);
    chk("bp_count", 32'(cnt_a), 19);
    chk("bp_queue", 32'(qa.size()), 0);
    cnt_a = 0;
    push_frame(0, seg, leds, bri, on, 1);
    wait_done_a(3, 400);
    chk("snap_count", 32'(cnt_a), 19);
    chk("snap_queue", 32'(qa.size()), 0);
    rst = 1'b1;
    on = 1'b0; bri = 3'd7;
    en_b = 1;
    step(2);
    cnt_a = 0; cnt_b = 0;
    push_frame(0, seg, leds, bri, on, 1);
    push_frame(1, seg, leds, bri, on, 0);
    rst = 1'b0;
    wait_done_a(4, 200);
    chk("off_count_a", 32'(cnt_a), 19);
    chk("noread_count_b", 32'(cnt_b), 18);
    chk("noread_queue_b", 32'(qb.size()), 0);
    en_b = 0;
    cnt_a = 0;
    push_frame(0, seg, leds, bri, on, 1);
    wait_cnt_a(9, 400);
    rst = 1'b1;
    step(1);
    chk("midrst_valid", 32'(a_valid), 0);
    chk("midrst_busy", 32'(a_busy), 0);
    chk("midrst_data", 32'(a_data), 0);
    qa.delete();
    push_frame(0, seg, leds, bri, on, 1);
    cnt_a = 0;
    rst = 1'b0;
    wait_done_a(5, 200);
    chk("restart_count", 32'(cnt_a), 19);
    chk("restart_queue", 32'(qa.size()), 0);
    en_a = 0;
    full_c = 1'b1;
    rst = 1'b1;
    step(1);
    en_c = 1;
    push_frame(2, seg, leds, bri, on, 1);
    push_frame(2, seg, leds, bri, on, 1);
    done_c = 0; cnt_c = 0;
    rst = 1'b0;
    step(100);
    chk("stall_nopush", 32'(cnt_c), 0);
    full_c = 1'b0;
    step(88);
    chk("overrun_frames", 32'(done_c), 2);
    chk("overrun_idle", 32'(c_busy), 0);
    chk("overrun_words", 32'(cnt_c), 38);
    chk("overrun_queue", 32'(qc.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
